// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (Booth radix-2) / divide (non-restoring) unit, fixed 33-cycle latency.
// Define MULTDIV_DIV_EN to build the divide datapath; otherwise DIV completes at once with an exception.
module multdiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int unsigned CNT_W = 5;
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
`ifdef MULTDIV_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_div_q, op_div_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
`ifdef MULTDIV_DIV_EN
    logic               rs_q, rs_d;
    logic               neg_q, neg_d;
    logic               div_inv_c;
    logic               div_sign_c;
`endif
    logic               start_c;
    logic               start_div_c;
    logic               booth_top_c;
    logic [WIDTH-1:0]   add_a, add_b, add_s;
    logic               add_c0, add_co;

    assign start_c     = ctrl_MULT | ctrl_DIV;
    assign start_div_c = ctrl_DIV & ~ctrl_MULT;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a start in any state restarts the unit
    always_comb begin
        state_d = state_q;
        if (start_c) begin
`ifdef MULTDIV_DIV_EN
            state_d = S_RUN;
`else
            state_d = start_div_c ? S_DONE : S_RUN;
`endif
        end else begin
            case (state_q)
                S_RUN:   if (cnt_q == LAST_ITER) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

`ifdef MULTDIV_DIV_EN
    // Divisor sign steers add vs. subtract, so |B| never has to be materialised
    assign div_inv_c  = ~rs_q ^ a_q[WIDTH-1];
    assign div_sign_c = hi_q[WIDTH-1] ^ add_b[WIDTH-1] ^ add_co;
`endif
    assign booth_top_c = hi_q[WIDTH-1] ^ add_b[WIDTH-1] ^ add_co;

    // Adder operand select: one evaluation per cycle
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_c0 = 1'b0;
        if (start_c) begin
`ifdef MULTDIV_DIV_EN
            if (start_div_c) begin
                add_a  = data_operandA ^ {WIDTH{data_operandA[WIDTH-1]}};
                add_c0 = data_operandA[WIDTH-1];
            end
`endif
        end else if (state_q == S_RUN) begin
`ifdef MULTDIV_DIV_EN
            if (op_div_q) begin
                add_a  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                add_b  = a_q ^ {WIDTH{div_inv_c}};
                add_c0 = div_inv_c;
            end else
`endif
            begin
                add_a = hi_q;
                case ({lo_q[0], qm1_q})
                    2'b01:   add_b = a_q;
                    2'b10: begin
                        add_b  = ~a_q;
                        add_c0 = 1'b1;
                    end
                    default: add_b = '0;
                endcase
            end
        end
`ifdef MULTDIV_DIV_EN
        else if (state_q == S_DONE && op_div_q) begin
            add_a  = lo_q ^ {WIDTH{neg_q}};
            add_c0 = neg_q;
        end
`endif
    end

    // Stand-in for the downstream carry-lookahead adder
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + SUM_W'(add_c0);

    // Datapath and output next values
    always_comb begin
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
        rs_d     = rs_q;
        neg_d    = neg_q;
`endif
        if (start_c) begin
            cnt_d    = '0;
            op_div_d = start_div_c;
            hi_d     = '0;
            qm1_d    = 1'b0;
            a_d      = data_operandA;
            lo_d     = data_operandB;
`ifdef MULTDIV_DIV_EN
            rs_d     = 1'b0;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (start_div_c) begin
                a_d  = data_operandB;
                lo_d = add_s;
            end
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef MULTDIV_DIV_EN
                    if (op_div_q) begin
                        hi_d = add_s;
                        rs_d = div_sign_c;
                        lo_d = {lo_q[WIDTH-2:0], ~div_sign_c};
                    end else
`endif
                    begin
                        hi_d  = {booth_top_c, add_s[WIDTH-1:1]};
                        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
                        qm1_d = lo_q[0];
                    end
                end
                S_DONE: begin
                    rdy_d = 1'b1;
                    if (op_div_q) begin
`ifdef MULTDIV_DIV_EN
                        result_d = (a_q == '0) ? '0 : add_s;
                        exc_d    = (a_q == '0) || (lo_q == MIN_VAL && !neg_q);
`else
                        result_d = '0;
                        exc_d    = 1'b1;
`endif
                    end else begin
                        result_d = lo_q;
                        exc_d    = (hi_q != {WIDTH{lo_q[WIDTH-1]}});
                    end
                end
                default: rdy_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            rs_q     <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef MULTDIV_DIV_EN
            rs_q     <= rs_d;
            neg_q    <= neg_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: directed vector table, abort/reset sequences and random ops vs. an arithmetic model.
module tb_multdiv_seq;
    localparam int unsigned W = 32;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  data_operandA, data_operandB;
    logic          ctrl_MULT, ctrl_DIV;
    logic [W-1:0]  data_result;
    logic          data_exception, data_resultRDY;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    multdiv_seq #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    typedef struct {
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input bit is_div);
        return (is_div && !DIV_EN) ? 1 : 33;
    endfunction

    // Reference: plain signed arithmetic
    function automatic void ref_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        logic [63:0] p;
        if (!is_div) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = p[31:0];
            e = (p != {{32{p[31]}}, p[31:0]});
        end else if (!DIV_EN || b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    // Call at a negedge: the next posedge is the start edge
    task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= 100 && !found; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                n = i;
                found = 1'b1;
            end
        end
    endtask

    task automatic quiet(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic run_one(input string tag, input bit m, input bit d, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ee);
        int n;
        logic [31:0] r;
        logic e;
        pulse(m, d, a, b);
        wait_rdy(n);
        r = data_result;
        e = data_exception;
        check({tag, ".lat"}, 32'(n), 32'(exp_lat(d && !m)));
        check({tag, ".res"}, r, er);
        check({tag, ".exc"}, 32'(e), 32'(ee));
        @(negedge clock);
        check({tag, ".rdyw"}, 32'(data_resultRDY), 32'd0);
        check({tag, ".hold"}, data_result, er);
    endtask

    initial begin
        vec_t vt[14];
        logic [31:0] er;
        logic ee;

        vt[0]  = '{1'b1, 1'b0, 32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vt[10] = '{1'b1, 1'b1, 32'd20,       32'd3,        32'd60,       1'b0};
        vt[11] = '{1'b0, 1'b1, 32'd20,       32'd3,        32'd6,        1'b0};
        vt[12] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
        vt[13] = '{1'b1, 1'b0, 32'hFFFF0000, 32'h00010000, 32'h00000000, 1'b1};

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("rst.res", data_result, 32'd0);
        check("rst.exc", 32'(data_exception), 32'd0);
        check("rst.rdy", 32'(data_resultRDY), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vt[i]) begin
            er = vt[i].r;
            ee = vt[i].e;
            if (vt[i].d && !vt[i].m && !DIV_EN) begin
                er = 32'd0;
                ee = 1'b1;
            end
            run_one($sformatf("vec%0d", i), vt[i].m, vt[i].d, vt[i].a, vt[i].b, er, ee);
        end

        // MULT aborted by a DIV ten cycles later
        pulse(1'b1, 1'b0, 32'd3, 32'd4);
        quiet(9, "abort.quiet");
        ref_op(1'b1, 32'd20, 32'd3, er, ee);
        run_one("abort.div", 1'b0, 1'b1, 32'd20, 32'd3, er, ee);

        // Restart landing on the DONE cycle suppresses the old RDY
        pulse(1'b1, 1'b0, 32'd6, 32'hFFFFFFF9);
        quiet(32, "redone.quiet");
        pulse(1'b1, 1'b0, 32'd5, 32'd5);
        check("redone.rdy", 32'(data_resultRDY), 32'd0);
        begin
            int n;
            wait_rdy(n);
            check("redone.lat", 32'(n), 32'd33);
            check("redone.res", data_result, 32'd25);
        end
        @(negedge clock);

        // Reset in cycle 15 of a multiply
        pulse(1'b1, 1'b0, 32'd1234, 32'd5678);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst.res", data_result, 32'd0);
        check("midrst.exc", 32'(data_exception), 32'd0);
        check("midrst.rdy", 32'(data_resultRDY), 32'd0);
        quiet(40, "midrst.quiet");
        run_one("midrst.next", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        pulse(1'b1, 1'b0, 32'd9, 32'd9);
        reset = 1'b0;
        quiet(40, "rststart.quiet");

        for (int k = 0; k < 40; k++) begin
            int sel;
            bit m, d;
            logic [31:0] a, b;
            sel = int'($urandom_range(0, 2));
            m = (sel != 1);
            d = (sel != 0);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = 32'(int'($urandom_range(0, 400)) - 200);
                b = 32'(int'($urandom_range(0, 400)) - 200);
            end
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            ref_op(d && !m, a, b, er, ee);
            run_one($sformatf("rnd%0d", k), m, d, a, b, er, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
